// File: rtl/param_shift_register.sv
// Loadable OUT_WIDTH shift register (SLL/SRL/SRA/ROL) with single-step and
// autonomous multi-cycle shift modes for the multiplier datapath.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting; load, start or en act directly on the register
// ST_SHIFT | multi-cycle shift running; one shift per edge, count down
module param_shift_register #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 16,
    parameter int CNT_W     = $clog2(OUT_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 sign_ext,
    input  logic [IN_WIDTH-1:0]  Num,
    input  logic [1:0]           mode,
    input  logic                 en,
    input  logic                 start,
    input  logic [CNT_W-1:0]     amount,
    output logic [OUT_WIDTH-1:0] Out,
    output logic                 carry_out,
    output logic                 busy,
    output logic                 done
);

    generate
        if (OUT_WIDTH < IN_WIDTH) begin : g_width_check
            $error("param_shift_register: OUT_WIDTH must be >= IN_WIDTH");
        end
    endgenerate

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]           state;
    logic [CNT_W-1:0]     count;
    logic [1:0]           mode_q;
    logic [OUT_WIDTH-1:0] ext_fill;
    logic [OUT_WIDTH-1:0] load_val;
    logic [OUT_WIDTH:0]   step_live;
    logic [OUT_WIDTH:0]   step_latched;

    // Result is {carry, shifted value}; written without slices so widths down to 1 elaborate.
    function automatic logic [OUT_WIDTH:0] shift_one(input logic [1:0] m,
                                                     input logic [OUT_WIDTH-1:0] v);
        case (m)
            2'b00:   return {v[OUT_WIDTH-1], v << 1};
            2'b01:   return {v[0], v >> 1};
            2'b10:   return {v[0], OUT_WIDTH'($unsigned($signed(v) >>> 1))};
            default: return {v[OUT_WIDTH-1], (v << 1) | OUT_WIDTH'(v[OUT_WIDTH-1])};
        endcase
    endfunction

    // Sign fill is shifted above the operand; vanishes when the widths are equal.
    assign ext_fill     = {OUT_WIDTH{sign_ext & Num[IN_WIDTH-1]}};
    assign load_val     = (ext_fill << IN_WIDTH) | OUT_WIDTH'(Num);
    assign step_live    = shift_one(mode, Out);
    assign step_latched = shift_one(mode_q, Out);
    assign busy         = (state == ST_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            Out       <= '0;
            carry_out <= 1'b0;
            done      <= 1'b0;
            state     <= ST_IDLE;
            count     <= '0;
            mode_q    <= 2'b00;
        end else begin
            done <= 1'b0;
            if (load) begin
                Out       <= load_val;
                carry_out <= 1'b0;
                state     <= ST_IDLE;
                count     <= '0;
            end else if (state == ST_SHIFT) begin
                {carry_out, Out} <= step_latched;
                count            <= count - CNT_W'(1);
                if (count == CNT_W'(1)) begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                end
            end else if (start) begin
                if (amount == CNT_W'(0)) begin
                    done <= 1'b1;
                end else begin
                    mode_q <= mode;
                    count  <= amount;
                    state  <= ST_SHIFT;
                end
            end else if (en) begin
                {carry_out, Out} <= step_live;
            end
        end
    end

endmodule

// File: tb/tb_param_shift_register.sv
// Directed self-checking bench for param_shift_register at the default
// 8-to-16 configuration; expected values are hand-computed.
module tb_param_shift_register;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic        sign_ext;
    logic [7:0]  Num;
    logic [1:0]  mode;
    logic        en;
    logic        start;
    logic [4:0]  amount;
    logic [15:0] Out;
    logic        carry_out;
    logic        busy;
    logic        done;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [1:0] M_SLL = 2'b00;
    localparam logic [1:0] M_SRL = 2'b01;
    localparam logic [1:0] M_SRA = 2'b10;
    localparam logic [1:0] M_ROL = 2'b11;

    param_shift_register #(.IN_WIDTH(8), .OUT_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .sign_ext  (sign_ext),
        .Num       (Num),
        .mode      (mode),
        .en        (en),
        .start     (start),
        .amount    (amount),
        .Out       (Out),
        .carry_out (carry_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [15:0] e_out, input logic e_c,
                               input logic e_busy, input logic e_done);
        check({tag, ".Out"},   32'(Out),       32'(e_out));
        check({tag, ".carry"}, 32'(carry_out), 32'(e_c));
        check({tag, ".busy"},  32'(busy),      32'(e_busy));
        check({tag, ".done"},  32'(done),      32'(e_done));
    endtask

    task automatic do_load(input logic [7:0] n, input logic sx, input logic [15:0] e_out);
        load = 1'b1; Num = n; sign_ext = sx;
        tick();
        load = 1'b0;
        check_state("load", e_out, 1'b0, 1'b0, 1'b0);
    endtask

    // Multi-cycle shift of n >= 1 bits: busy through the run, one done pulse at the end.
    task automatic run_shift(input string tag, input logic [1:0] m, input logic [4:0] n,
                             input logic [15:0] e_out, input logic e_c);
        logic [15:0] held;
        held = Out;
        mode = m; amount = n; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, ".start_busy"}, 32'(busy), 32'd1);
        check({tag, ".start_hold"}, 32'(Out), 32'(held));
        for (int i = 1; i <= int'(n); i++) begin
            tick();
            if (i < int'(n)) begin
                check({tag, ".mid_busy"}, 32'(busy), 32'd1);
                check({tag, ".mid_done"}, 32'(done), 32'd0);
            end
        end
        check_state({tag, ".end"}, e_out, e_c, 1'b0, 1'b1);
        tick();
        check({tag, ".done_clear"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; sign_ext = 1'b0; Num = '0; mode = M_SLL;
        en = 1'b0; start = 1'b0; amount = '0;
        tick();
        check_state("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Legacy equivalence: zero-extend then three single steps left
        do_load(8'h81, 1'b0, 16'h0081);
        mode = M_SLL; en = 1'b1;
        tick(); tick(); tick();
        en = 1'b0;
        check_state("legacy_sll3", 16'h0408, 1'b0, 1'b0, 1'b0);
        tick();
        check("en_low_hold", 32'(Out), 32'h0408);

        // Single-step rotate using live mode
        do_load(8'h80, 1'b1, 16'hFF80);
        mode = M_ROL; en = 1'b1;
        tick();
        en = 1'b0;
        check_state("rol_step", 16'hFF01, 1'b1, 1'b0, 1'b0);

        // Sign-extended arithmetic shift right
        do_load(8'h85, 1'b1, 16'hFF85);
        run_shift("sra3", M_SRA, 5'd3, 16'hFFF0, 1'b1);

        // SLL then SRL multi-cycle
        do_load(8'hB3, 1'b0, 16'h00B3);
        run_shift("sll4", M_SLL, 5'd4, 16'h0B30, 1'b0);
        run_shift("srl8", M_SRL, 5'd8, 16'h000B, 1'b0);

        // Full rotate wraps back; then zero-amount start
        do_load(8'hB3, 1'b0, 16'h00B3);
        run_shift("rol16", M_ROL, 5'd16, 16'h00B3, 1'b1);
        amount = 5'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check_state("amt0", 16'h00B3, 1'b1, 1'b0, 1'b1);
        tick();
        check_state("amt0_after", 16'h00B3, 1'b1, 1'b0, 1'b0);

        // Amount beyond width saturates to the sign
        do_load(8'h85, 1'b1, 16'hFF85);
        run_shift("sra20", M_SRA, 5'd20, 16'hFFFF, 1'b1);

        // Abort and ignore during an 8-bit SRA
        do_load(8'h85, 1'b1, 16'hFF85);
        mode = M_SRA; amount = 5'd8; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_state("abort_s1", 16'hFFC2, 1'b1, 1'b1, 1'b0);
        en = 1'b1; start = 1'b1; mode = M_SLL; amount = 5'd1;
        tick();
        en = 1'b0; start = 1'b0;
        check_state("abort_s2_ignored", 16'hFFE1, 1'b0, 1'b1, 1'b0);
        tick();
        check_state("abort_s3", 16'hFFF0, 1'b1, 1'b1, 1'b0);
        load = 1'b1; Num = 8'h12; sign_ext = 1'b0;
        tick();
        load = 1'b0;
        check_state("abort_load", 16'h0012, 1'b0, 1'b0, 1'b0);
        tick();
        check_state("abort_no_done", 16'h0012, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a 5-bit SLL
        mode = M_SLL; amount = 5'd5; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_state("rst_s1", 16'h0024, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_state("rst_mid", 16'h0000, 1'b0, 1'b0, 1'b0);
        tick();
        check_state("rst_after", 16'h0000, 1'b0, 1'b0, 1'b0);
        do_load(8'h01, 1'b0, 16'h0001);
        run_shift("post_rst_sll5", M_SLL, 5'd5, 16'h0020, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/param_shift_register.md
Name: param_shift_register

Overview:
- Parametrised successor to the fixed 8-to-16 shift-left register used by the signed multiplier datapath.
- Loads an IN_WIDTH operand into an OUT_WIDTH register, zero- or sign-extended.
- Shifts it in one of four modes, either one bit per `en` pulse or as an autonomous multi-cycle shift of a programmed amount with busy/done handshake.
- Feeds partial-product and alignment paths in the next-generation multiplier.

Parameters:
- IN_WIDTH, 8, width of the loaded operand `Num`.
- OUT_WIDTH, 16, width of `Out`; must be >= IN_WIDTH (elaboration error otherwise).
- CNT_W, $clog2(OUT_WIDTH+1), width of `amount` and of the internal shift counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- load  input  1  load `Num` into `Out`
- sign_ext  input  1  with load: 1 = sign-extend `Num`, 0 = zero-extend
- Num  input  IN_WIDTH  operand to load
- mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL
- en  input  1  single-step shift by one bit in `mode`
- start  input  1  begin multi-cycle shift of `amount` bits
- amount  input  CNT_W  bit count for `start`
- Out  output  OUT_WIDTH  register contents
- carry_out  output  1  last bit shifted out (wrapped bit for ROL)
- busy  output  1  multi-cycle shift in progress
- done  output  1  one-cycle pulse when the multi-cycle shift completes

Behaviour:
- Clock and reset: one clock, `clk`; reset is synchronous and active-high (`rst`). All state updates on the rising edge of `clk`.
- Reset values: Out = 0, carry_out = 0, busy = 0, done = 0, counter = 0, latched mode = 00.
- Priority each edge: rst > load > busy-shift > start > en.
- load:
  - Out <= Num extended to OUT_WIDTH (zero-extend, or replicate Num[IN_WIDTH-1] when sign_ext = 1); carry_out <= 0; done <= 0.
  - If busy, the operation aborts: busy <= 0, no done pulse.
- One-bit shift per mode:
  - SLL: Out <= {Out[W-2:0], 0}; carry_out <= Out[W-1].
  - SRL: Out <= {0, Out[W-1:1]}; carry_out <= Out[0].
  - SRA: Out <= {Out[W-1], Out[W-1:1]}; carry_out <= Out[0].
  - ROL: Out <= {Out[W-2:0], Out[W-1]}; carry_out <= Out[W-1].
- Single-step en (busy = 0, no load, no start): one shift using the live `mode`. Otherwise Out and carry_out hold.
- start while idle, amount = N >= 1:
  - Start edge: latch mode and counter <= N, busy <= 1, no shift.
  - Each following edge while busy: one shift using the latched mode, counter decrements.
  - On the edge performing the Nth shift: busy <= 0, done <= 1.
  - Shifts occur on edges 1..N after the start edge; done is high for exactly the cycle after edge N.
- start with amount = 0: done <= 1 on the start edge, busy stays 0, Out unchanged.
- start or en while busy: ignored. mode/amount changes while busy: no effect.
- done is cleared on every edge it is not being set.
- amount > OUT_WIDTH is legal and performs that many shifts: SLL/SRL saturate to all-zero, SRA to all-sign, ROL wraps.
- rst mid-operation: next edge returns all outputs to reset values, counter cleared, no done.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Legacy equivalence: rst; load Num = 0x81, sign_ext = 0 -> Out = 0x0081; en for 3 cycles, mode SLL -> Out = 0x0408, carry_out = 0.
- Sign-extended SRA: load Num = 0x85, sign_ext = 1 -> Out = 0xFF85; start with amount = 3, mode SRA -> busy high 3 cycles, then Out = 0xFFF0, carry_out = 1, done high exactly one cycle, busy low.
- SLL/SRL multi-cycle: load 0xB3 (zero-ext) -> 0x00B3; start amount = 4, SLL -> Out = 0x0B30, carry_out = 0; then start amount = 8, SRL -> Out = 0x000B, carry_out = 0.
- Rotate wrap and zero amount: load 0xB3 -> 0x00B3; start amount = 16, ROL -> Out = 0x00B3 after 16 shifts, done once; start amount = 0 -> done next cycle, busy never high, Out unchanged.
- Abort and ignore: during SRA amount = 8 on 0xFF85, pulse en and start at shift 2 -> ignored; assert load Num = 0x12 at shift 4 -> Out = 0x0012, busy = 0, no done pulse.
- Reset mid-operation: assert rst at shift 2 of a 5-bit SLL -> next edge Out = 0, carry_out = 0, busy = 0, done = 0; a new start afterwards operates normally.
